fetch_sequencer: RTL

//  Owns the architectural instruction-pointer register and sequences instruction fetch for the core.

---
 rtl/fetch_sequencer_pkg.sv | 23 ++
 rtl/fetch_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and default constants for the instruction fetch sequencer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package fetch_sequencer_pkg;

   // REQ   : presenting a read request to instruction memory
   // WAIT  : request accepted, waiting for the single response
   // ISSUE : instruction held on the core interface until accepted
   // HALT  : idle, no requests until halt_req is released
   typedef enum logic [1:0] {
      REQ   = 2'd0,
      WAIT  = 2'd1,
      ISSUE = 2'd2,
      HALT  = 2'd3
   } fetch_state_t;

   // Pointer pair {addr0,addr1} loaded into the instruction pointer at reset.
   localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0001;

   // Width of the saturating fetch-stall counter.
   localparam int STALL_CNT_W_DEFAULT = 16;

endpackage

// File: rtl/fetch_sequencer.sv
// Owns the instruction pointer and sequences two-word fetches from memory to the core.
// Latency: request accept to instr_valid = memory latency + 1 cycle.
// Backpressure: valid/ready both sides; one request in flight; instruction held until instr_ready.
//
// Ports:
//   clk, rst_n                     core clock, asynchronous active-low reset
//   mem_req_valid/ready, mem_addr  read request {addr0,addr1} to instruction memory
//   mem_rsp_valid, mem_rsp_data    one response per accepted request, no ready
//   instr_valid/ready              assembled instruction + pointer handed to the core
//   instruction, instr_pointer     fetched data and the pointer pair it came from
//   next_pointer                   successor pair from the external pointer counter
//   redirect, redirect_ptr         flush and restart fetch at a new pointer pair
//   halt_req, halted               level halt request and idle indication
//   stall_cnt                      saturating count of cycles without an instruction offered
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
   parameter int          STALL_CNT_W  = STALL_CNT_W_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output logic                   mem_req_valid,
   input  logic                   mem_req_ready,
   output logic [31:0]            mem_addr,
   input  logic                   mem_rsp_valid,
   input  logic [31:0]            mem_rsp_data,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic [31:0]            instruction,
   output logic [31:0]            instr_pointer,
   input  logic [31:0]            next_pointer,
   input  logic                   redirect,
   input  logic [31:0]            redirect_ptr,
   input  logic                   halt_req,
   output logic                   halted,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   fetch_state_t state, state_nxt;
   logic [31:0]  ip;
   logic [31:0]  instr_q;
   logic         discard;     // a response still owed by memory must be thrown away
   logic         req_held;    // request was presented last cycle and not yet accepted
   logic         req_fire;
   logic         redirect_outstanding;

   // The pointer counter lives outside this block; next_pointer is its
   // combinational result and is consumed unchanged, so 16-bit half
   // wrap-around is entirely the counter's business.

   always_comb begin
      state_nxt     = state;
      mem_req_valid = 1'b0;
      unique case (state)
         REQ: begin
            // While a stale response is owed, hold off so memory never sees
            // two requests in flight.
            if (!discard) begin
               // halt_req only takes effect before a request is shown; once
               // presented, the request stays up until accepted.
               if (halt_req && !req_held) begin
                  state_nxt = HALT;
               end else begin
                  // Gated by rst_n so nothing is requested while in reset.
                  mem_req_valid = rst_n;
                  if (mem_req_ready) begin
                     state_nxt = WAIT;
                  end
               end
            end
         end
         WAIT: begin
            if (mem_rsp_valid) begin
               state_nxt = discard ? REQ : ISSUE;
            end
         end
         ISSUE: begin
            if (instr_ready) begin
               state_nxt = halt_req ? HALT : REQ;
            end
         end
         HALT: begin
            if (!halt_req) begin
               state_nxt = REQ;
            end
         end
         default: state_nxt = REQ;
      endcase
      // Redirect overrides everything, including HALT and a same-cycle accept.
      if (redirect) begin
         state_nxt = REQ;
      end
   end

   assign req_fire = mem_req_valid && mem_req_ready;

   // On redirect, a response is still owed if we are waiting and it has not
   // arrived this cycle, if a request is being accepted right now, or if an
   // earlier stale response is still pending.
   assign redirect_outstanding = ((state == WAIT) && !mem_rsp_valid) ||
                                 req_fire ||
                                 (discard && !mem_rsp_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= REQ;
         ip        <= RESET_VECTOR;
         instr_q   <= '0;
         discard   <= 1'b0;
         req_held  <= 1'b0;
         stall_cnt <= '0;
      end else begin
         state    <= state_nxt;
         req_held <= mem_req_valid && !mem_req_ready && !redirect;

         if (redirect) begin
            discard <= redirect_outstanding;
         end else if (discard && mem_rsp_valid) begin
            discard <= 1'b0;
         end

         if (redirect) begin
            ip <= redirect_ptr;
         end else if ((state == ISSUE) && instr_ready) begin
            ip <= next_pointer;
         end

         if (!redirect && (state == WAIT) && mem_rsp_valid && !discard) begin
            instr_q <= mem_rsp_data;
         end

         if ((state != HALT) && !instr_valid && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
         end
      end
   end

   // ip only moves on accept or redirect, so it doubles as the stable
   // request address and as the pointer of the instruction on offer.
   assign mem_addr      = ip;
   assign instr_pointer = ip;
   assign instruction   = instr_q;
   assign instr_valid   = (state == ISSUE);
   assign halted        = (state == HALT);

endmodule
